operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage for the sequential RISC-V core, placed between decode and execute. Accepts decoded instructions on a valid/ready handshake and drives the read addresses of the 32×64-bit register file. Captures rs1/rs2 operands into a one-entry output register with a 32-bit scoreboard that blocks RAW and WAW hazards against results still in flight. Observes the writeback port, which also feeds the register file, to clear scoreboard bits and optionally bypass write data.

## Interface
Parameters:
- XLEN, 64, operand/PC width
- RA_W, 5, register address width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1_addr, in_rs2_addr  in  RA_W  source registers
- in_rd_addr  in  RA_W  destination register
- in_rd_en  in  1  instruction writes rd
- in_pc  in  XLEN  instruction PC
- rf_rs1_addr, rf_rs2_addr  out  RA_W  register file read addresses; combinational copy of in_rs1_addr/in_rs2_addr
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data, combinational
- wb_valid  in  1  writeback this cycle; same strobe as register file reg_write
- wb_rd_addr  in  RA_W  writeback destination
- wb_rd_data  in  XLEN  writeback data
- flush  in  1  synchronous kill of held instruction
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_rs1_data, out_rs2_data  out  XLEN  captured operands
- out_rd_addr  out  RA_W; out_rd_en  out  1; out_pc  out  XLEN  forwarded fields
- sb_pending  out  32  scoreboard, bit n = write to xn outstanding; bit 0 always 0

## Operation
- Hold register: one entry (out_*); out_valid set on accept, cleared on out handshake with no new accept, or on flush.
- Scoreboard set: on out handshake with out_rd_en=1 and out_rd_addr≠0, set sb_pending[out_rd_addr].
- Scoreboard clear: on wb_valid with wb_rd_addr≠0, clear sb_pending[wb_rd_addr]. Same cycle, same index set and clear: set wins (set belongs to the newer instruction).
- Source hazard per rs (rs≠0):
  - scoreboard bit pending, or
  - out_valid && out_rd_en && out_rd_addr==rs (held instruction not yet issued).
  - With bypass: a pending bit whose clear arrives this cycle (wb_valid && wb_rd_addr==rs) is not a hazard.
- WAW hazard: in_rd_en && in_rd_addr≠0 && sb_pending[in_rd_addr], or the held instruction writes the same rd.
- in_ready = (!out_valid || out_ready) && !hazard && !flush. in_ready may depend on in_* fields, never on in_valid.
- Operand select per rs, in priority order:
  1. rs==0 → 0
  2. bypass built in, wb_valid && wb_rd_addr==rs → wb_rd_data
  3. otherwise rf_rsX_data
- flush: out_valid←0 next edge; no accept that cycle. Scoreboard untouched, because issued writes still return.

## Timing
- Reset (rst_n low, async): out_valid=0, out_rs1_data=out_rs2_data=0, out_rd_addr=0, out_rd_en=0, out_pc=0, sb_pending=0. in_ready follows its combinational equation (1 after reset with no hazard).
- Latency: accept at edge N → out_valid high after edge N; throughput 1 instr/cycle when no hazard and out_ready=1.
- Accept and issue may occur in the same cycle (hold register refills).
- Reset release mid-stream: anything presented before release is lost; no partial scoreboard state survives.

## Configuration
- OPERAND_FETCH_BYPASS_EN defined: same-cycle wb data bypassed into captured operands; dependent instruction accepted in the writeback cycle.
- Not defined: no bypass mux. Any scoreboard bit set at the start of the cycle is a hazard, so the dependent instruction is accepted one cycle after writeback, reading the committed register file value.

## Test plan
- Reset: assert rst_n=0 mid-cycle with out_valid=1 → out_valid=0, sb_pending=0 immediately, outputs 0.
- Back-to-back independent: ADD x1←x2,x3 then SUB x4←x5,x6, regs 2,3,5,4, out_ready=1 → operands (2,3) then (5,4) on consecutive cycles, sb_pending bits 1 and 4 set.
- RAW stall: issue rd=x7, then instruction reading x7; wb x7=5 three cycles later → in_ready=0 until wb. With bypass, accepted in wb cycle with out_rs1_data=5; without bypass, accepted one cycle later with 5.
- x0: instruction with rs1=x0, rd=x0, rf_rs1_data forced 0xDEAD → out_rs1_data=0, sb_pending[0]=0, no stall.
- Set/clear collision: wb x9 while issuing new rd=x9 in same cycle → sb_pending[9]=1 afterwards.
- Backpressure + flush: out_ready=0 for 4 cycles → out_* stable, in_ready=0. Then flush=1 → out_valid=0 next cycle, scoreboard unchanged.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: captures rs1/rs2 operands into a one-entry hold register and
// blocks RAW/WAW hazards with a scoreboard. Optional bypass: OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic            in_rd_en,
  input  logic [XLEN-1:0] in_pc,
  output logic [RA_W-1:0] rf_rs1_addr,
  output logic [RA_W-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [RA_W-1:0] out_rd_addr,
  output logic            out_rd_en,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     sb_pending
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and in_ready never looks at in_valid.

  logic            r_valid;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [RA_W-1:0] r_rd_addr;
  logic            r_rd_en;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_sb;

  logic            w_wb_live;
  logic            w_byp1;
  logic            w_byp2;
  logic            w_held_wr1;
  logic            w_held_wr2;
  logic            w_rs1_haz;
  logic            w_rs2_haz;
  logic            w_waw_haz;
  logic            w_ready;
  logic            w_accept;
  logic            w_issue;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [31:0]     w_sb_next;

  assign rf_rs1_addr = in_rs1_addr;
  assign rf_rs2_addr = in_rs2_addr;

  assign w_wb_live = wb_valid && (wb_rd_addr != '0);

`ifdef OPERAND_FETCH_BYPASS_EN
  assign w_byp1 = w_wb_live && (wb_rd_addr == in_rs1_addr);
  assign w_byp2 = w_wb_live && (wb_rd_addr == in_rs2_addr);
`else
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^wb_rd_data;
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // The held instruction has not set its scoreboard bit yet, so match it directly.
  assign w_held_wr1 = r_valid && r_rd_en && (r_rd_addr == in_rs1_addr);
  assign w_held_wr2 = r_valid && r_rd_en && (r_rd_addr == in_rs2_addr);

  assign w_rs1_haz = (in_rs1_addr != '0) &&
                     ((r_sb[in_rs1_addr] && !w_byp1) || w_held_wr1);
  assign w_rs2_haz = (in_rs2_addr != '0) &&
                     ((r_sb[in_rs2_addr] && !w_byp2) || w_held_wr2);
  assign w_waw_haz = in_rd_en && (in_rd_addr != '0) &&
                     (r_sb[in_rd_addr] ||
                      (r_valid && r_rd_en && (r_rd_addr == in_rd_addr)));

  assign w_ready  = (!r_valid || out_ready) && !w_rs1_haz && !w_rs2_haz &&
                    !w_waw_haz && !flush;
  assign w_accept = in_valid && w_ready;
  // A flushed instruction is killed, so it never reaches execute or the scoreboard.
  assign w_issue  = r_valid && out_ready && !flush;

  always_comb begin
    w_op1 = rf_rs1_data;
    if (in_rs1_addr == '0)  w_op1 = '0;
`ifdef OPERAND_FETCH_BYPASS_EN
    else if (w_byp1)        w_op1 = wb_rd_data;
`endif
    else                    w_op1 = rf_rs1_data;
  end

  always_comb begin
    w_op2 = rf_rs2_data;
    if (in_rs2_addr == '0)  w_op2 = '0;
`ifdef OPERAND_FETCH_BYPASS_EN
    else if (w_byp2)        w_op2 = wb_rd_data;
`endif
    else                    w_op2 = rf_rs2_data;
  end

  // Set is applied after clear so the newer instruction's claim survives a collision.
  always_comb begin
    w_sb_next = r_sb;
    if (w_wb_live) w_sb_next[wb_rd_addr] = 1'b0;
    if (w_issue && r_rd_en && (r_rd_addr != '0)) w_sb_next[r_rd_addr] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd_addr  <= '0;
      r_rd_en    <= 1'b0;
      r_pc       <= '0;
      r_sb       <= '0;
    end else begin
      if (flush)         r_valid <= 1'b0;
      else if (w_accept) r_valid <= 1'b1;
      else if (w_issue)  r_valid <= 1'b0;
      if (w_accept) begin
        r_rs1_data <= w_op1;
        r_rs2_data <= w_op2;
        r_rd_addr  <= in_rd_addr;
        r_rd_en    <= in_rd_en;
        r_pc       <= in_pc;
      end
      r_sb <= w_sb_next;
    end
  end

  assign in_ready     = w_ready;
  assign out_valid    = r_valid;
  assign out_rs1_data = r_rs1_data;
  assign out_rs2_data = r_rs2_data;
  assign out_rd_addr  = r_rd_addr;
  assign out_rd_en    = r_rd_en;
  assign out_pc       = r_pc;
  assign sb_pending   = r_sb;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and random checks of operand_fetch against a
// register-file / pending-set reference model kept in the bench.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_rd_en;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [63:0] in_pc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [63:0] rf_rs1_data, rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_rd_data;
  logic        flush, out_valid, out_ready, out_rd_en;
  logic [63:0] out_rs1_data, out_rs2_data, out_pc;
  logic [4:0]  out_rd_addr;
  logic [31:0] sb_pending;

  logic [63:0] rf [32];
  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(64), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_rd_en(in_rd_en), .in_pc(in_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd_addr(out_rd_addr), .out_rd_en(out_rd_en), .out_pc(out_pc),
    .sb_pending(sb_pending)
  );

  // Reference model: the held instruction plus the set of registers awaiting writeback.
  bit          m_valid;
  logic [63:0] m_op1, m_op2, m_pc;
  logic [4:0]  m_rd;
  bit          m_rd_en;
  bit          m_pend [32];
  bit          m_acc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit src_blocked(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (m_valid && m_rd_en && m_rd == rs) return 1'b1;
    if (m_pend[rs]) return !(BYP && wb_valid && wb_rd_addr == rs);
    return 1'b0;
  endfunction

  function automatic bit model_ready();
    bit waw;
    waw = in_rd_en && in_rd_addr != 5'd0 &&
          (m_pend[in_rd_addr] || (m_valid && m_rd_en && m_rd == in_rd_addr));
    return (!m_valid || out_ready) && !flush && !waw &&
           !src_blocked(in_rs1_addr) && !src_blocked(in_rs2_addr);
  endfunction

  function automatic logic [63:0] operand(input logic [4:0] rs);
    if (rs == 5'd0) return 64'd0;
    if (BYP && wb_valid && wb_rd_addr == rs) return wb_rd_data;
    return rf[rs];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op1 = '0; m_op2 = '0; m_pc = '0; m_rd = '0; m_rd_en = 0; m_acc = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "out_valid"},    64'(out_valid),    64'(m_valid));
    chk({pfx, "out_rs1_data"}, out_rs1_data,      m_op1);
    chk({pfx, "out_rs2_data"}, out_rs2_data,      m_op2);
    chk({pfx, "out_rd_addr"},  64'(out_rd_addr),  64'(m_rd));
    chk({pfx, "out_rd_en"},    64'(out_rd_en),    64'(m_rd_en));
    chk({pfx, "out_pc"},       out_pc,            m_pc);
    chk({pfx, "sb_pending"},   64'(sb_pending),   64'(pend_vec()));
  endtask

  // One clock: check combinational outputs, cross the edge, advance model, check state.
  task automatic tick();
    bit          rdy, iss;
    logic [63:0] o1, o2;
    #1;
    rdy = model_ready();
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("rf_rs1_addr", 64'(rf_rs1_addr), 64'(in_rs1_addr));
    chk("rf_rs2_addr", 64'(rf_rs2_addr), 64'(in_rs2_addr));
    m_acc = in_valid && rdy;
    iss   = m_valid && out_ready && !flush;
    o1    = operand(in_rs1_addr);
    o2    = operand(in_rs2_addr);
    @(posedge clk);
    #1;
    if (wb_valid && wb_rd_addr != 5'd0) begin
      m_pend[wb_rd_addr] = 0;
      rf[wb_rd_addr] = wb_rd_data;
    end
    if (iss && m_rd_en && m_rd != 5'd0) m_pend[m_rd] = 1;
    if (flush)      m_valid = 0;
    else if (m_acc) m_valid = 1;
    else if (iss)   m_valid = 0;
    if (m_acc) begin
      m_op1 = o1; m_op2 = o2; m_rd = in_rd_addr; m_rd_en = in_rd_en; m_pc = in_pc;
    end
    check_outputs("");
  endtask

  task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit rd_en, input logic [63:0] pc);
    in_valid = v; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rd_addr = rd; in_rd_en = rd_en; in_pc = pc;
  endtask

  task automatic wb(input bit v, input logic [4:0] rd, input logic [63:0] data);
    wb_valid = v; wb_rd_addr = rd; wb_rd_data = data;
  endtask

  initial begin
    int          acc_k;
    logic [31:0] sb_before;
    drive(0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    flush = 0; out_ready = 1;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[0] = 64'd0;
    model_reset();

    // Reset state
    #12;
    check_outputs("reset_");
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick();

    // Back-to-back independent: ADD x1<-x2,x3 then SUB x4<-x5,x6
    rf[2] = 64'd2; rf[3] = 64'd3; rf[5] = 64'd5; rf[6] = 64'd4;
    drive(1, 2, 3, 1, 1, 64'h100);
    tick();
    chk("b2b_op1_first", out_rs1_data, 64'd2);
    chk("b2b_op2_first", out_rs2_data, 64'd3);
    drive(1, 5, 6, 4, 1, 64'h104);
    tick();
    chk("b2b_op1_second", out_rs1_data, 64'd5);
    chk("b2b_op2_second", out_rs2_data, 64'd4);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("b2b_sb", 64'(sb_pending), 64'h12);
    wb(1, 1, 64'h11); tick();
    wb(1, 4, 64'h44); tick();
    wb(0, 0, 0);
    chk("b2b_sb_cleared", 64'(sb_pending), 64'h0);

    // RAW stall on x7, writeback of 5 arrives on loop step 2
    drive(1, 0, 0, 7, 1, 64'h200); tick();
    drive(0, 0, 0, 0, 0, 0);       tick();
    chk("raw_sb7", 64'(sb_pending[7]), 64'd1);
    drive(1, 7, 0, 8, 1, 64'h204);
    acc_k = -1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) wb(1, 7, 64'd5);
      else        wb(0, 0, 0);
      tick();
      if (m_acc) begin
        acc_k = k;
        break;
      end
    end
    wb(0, 0, 0);
    chk("raw_accept_step", 64'(acc_k), BYP ? 64'd2 : 64'd3);
    chk("raw_op1", out_rs1_data, 64'd5);
    drive(0, 0, 0, 0, 0, 0); tick();

    // x0 handling: garbage on x0 read port must not leak, rd=x0 never pends
    rf[0] = 64'hDEAD;
    drive(1, 0, 2, 0, 1, 64'h300); tick();
    chk("x0_accepted", 64'(out_valid), 64'd1);
    chk("x0_op1", out_rs1_data, 64'd0);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("x0_sb0", 64'(sb_pending[0]), 64'd0);
    rf[0] = 64'd0;

    // Set/clear collision on x9
    drive(1, 0, 0, 9, 1, 64'h400); tick();
    drive(0, 0, 0, 0, 0, 0); out_ready = 0; tick();
    out_ready = 1; wb(1, 9, 64'd77); tick();
    chk("collide_sb9", 64'(sb_pending[9]), 64'd1);
    tick();
    wb(0, 0, 0);
    chk("collide_sb9_cleared", 64'(sb_pending[9]), 64'd0);

    // Backpressure then flush
    drive(1, 2, 3, 10, 1, 64'h500); tick();
    out_ready = 0;
    drive(1, 5, 6, 11, 1, 64'h504);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_pc", out_pc, 64'h500);
    end
    sb_before = pend_vec();
    flush = 1; tick();
    flush = 0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_sb", 64'(sb_pending), 64'(sb_before));
    tick();
    chk("after_flush_pc", out_pc, 64'h504);
    drive(0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle while holding an instruction
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset_");
    #1;
    rst_n = 1'b1;
    out_ready = 1;
    tick();

    // Randomized traffic on a small register window to provoke hazards
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      wb($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), {$urandom, $urandom});
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
